// File: rtl/uart_cfg_csr.sv
// uart_cfg_csr
//   Runtime-programmable UART configuration registers. Software writes
//   parity, frame format and baud divisor into shadow registers. A CMD apply
//   request copies the whole shadow set into the active outputs. The copy
//   happens on the first edge at which the UART reports idle.
//
//   Register port handshake: i_wr_en and i_rd_en are single-cycle strobes
//   that are always accepted, and there is no ready signal. A read strobed
//   in cycle N returns o_rdata with o_rvalid=1 in cycle N+1. o_rdata holds
//   its last value while o_rvalid=0. A read and a write in the same cycle
//   are both served, and the read sees the pre-write contents.
//
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     i_wr_en, i_rd_en  register write / read strobes
//     i_addr, i_wdata   word address and write data
//     o_rdata, o_rvalid read data and its one-cycle valid
//     i_uart_busy       a TX or RX frame is in progress (blocks commit)
//     o_parity_enable, o_parity_type, o_stop2, o_data_bits, o_baud_div
//                       active UART configuration (registered)
//     o_cfg_update      one-cycle pulse after the active set was reloaded
//     o_pending         an apply request is waiting for an idle UART
//
//   Register map:
//     0 CTRL        {data_bits[4:3], stop2[2], parity_type[1], parity_en[0]}
//     1 BAUD        divisor; a value below 2 is rejected and sets err
//     2 CMD         bit0 apply, bit1 clear err (reads 0)
//     3 STATUS      {busy[2], err[1], pending[0]}
//     4 ACTIVE      CTRL layout of the active outputs
//     5 ACTIVE_BAUD active divisor
module uart_cfg_csr #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int DEF_BAUD        = 115200,
    parameter int DIV_W           = 16,
    parameter int DATA_W          = 32,
    parameter int DEF_PARITY_EN   = 1,
    parameter int DEF_PARITY_TYPE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [2:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    input  logic              i_uart_busy,
    output logic              o_parity_enable,
    output logic              o_parity_type,
    output logic              o_stop2,
    output logic [1:0]        o_data_bits,
    output logic [DIV_W-1:0]  o_baud_div,
    output logic              o_cfg_update,
    output logic              o_pending
);

    localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(CLK_FREQ / DEF_BAUD);
    localparam logic             RST_PEN   = 1'(DEF_PARITY_EN);
    localparam logic             RST_PTYPE = 1'(DEF_PARITY_TYPE);

    localparam logic [2:0] A_CTRL        = 3'd0;
    localparam logic [2:0] A_BAUD        = 3'd1;
    localparam logic [2:0] A_CMD         = 3'd2;
    localparam logic [2:0] A_STATUS      = 3'd3;
    localparam logic [2:0] A_ACTIVE      = 3'd4;
    localparam logic [2:0] A_ACTIVE_BAUD = 3'd5;

    // Shadow set
    logic             sh_pen;
    logic             sh_ptype;
    logic             sh_stop2;
    logic [1:0]       sh_bits;
    logic [DIV_W-1:0] sh_div;

    logic             pending;
    logic             err;

    logic             wr_ctrl;
    logic             wr_baud;
    logic             wr_cmd;
    logic             baud_ok;
    logic             apply_req;
    logic             err_clr;
    logic             commit;
    logic [DATA_W-1:0] rd_mux;

    // Write data bits above the divisor width are never stored.
    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

    assign wr_ctrl   = i_wr_en && (i_addr == A_CTRL);
    assign wr_baud   = i_wr_en && (i_addr == A_BAUD);
    assign wr_cmd    = i_wr_en && (i_addr == A_CMD);
    assign baud_ok   = i_wdata[DIV_W-1:0] >= DIV_W'(2);
    assign apply_req = wr_cmd && i_wdata[0];
    assign err_clr   = wr_cmd && i_wdata[1];
    assign commit    = pending && !i_uart_busy;

    assign o_pending = pending;

    // Shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pen   <= RST_PEN;
            sh_ptype <= RST_PTYPE;
            sh_stop2 <= 1'b0;
            sh_bits  <= 2'd3;
            sh_div   <= RST_DIV;
        end else begin
            if (wr_ctrl) begin
                sh_pen   <= i_wdata[0];
                sh_ptype <= i_wdata[1];
                sh_stop2 <= i_wdata[2];
                sh_bits  <= i_wdata[4:3];
            end
            if (wr_baud && baud_ok) begin
                sh_div <= i_wdata[DIV_W-1:0];
            end
        end
    end

    // Apply request and sticky error. An apply written in the commit cycle
    // keeps pending set so that a second commit follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            err     <= 1'b0;
        end else begin
            pending <= apply_req | (pending & ~commit);
            if (wr_baud && !baud_ok) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // Active set. These registers load only at commit, so shadow writes in
    // the commit cycle are not seen until the next apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_parity_enable <= RST_PEN;
            o_parity_type   <= RST_PTYPE;
            o_stop2         <= 1'b0;
            o_data_bits     <= 2'd3;
            o_baud_div      <= RST_DIV;
            o_cfg_update    <= 1'b0;
        end else begin
            o_cfg_update <= commit;
            if (commit) begin
                o_parity_enable <= sh_pen;
                o_parity_type   <= sh_ptype;
                o_stop2         <= sh_stop2;
                o_data_bits     <= sh_bits;
                o_baud_div      <= sh_div;
            end
        end
    end

    // Read mux. It is built from current register values, so a read in the
    // same cycle as a write returns the pre-write contents.
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            A_CTRL:        rd_mux[4:0]       = {sh_bits, sh_stop2, sh_ptype, sh_pen};
            A_BAUD:        rd_mux[DIV_W-1:0] = sh_div;
            A_STATUS:      rd_mux[2:0]       = {i_uart_busy, err, pending};
            A_ACTIVE:      rd_mux[4:0]       = {o_data_bits, o_stop2, o_parity_type, o_parity_enable};
            A_ACTIVE_BAUD: rd_mux[DIV_W-1:0] = o_baud_div;
            default:       rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= i_rd_en;
            if (i_rd_en) begin
                o_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_uart_cfg_csr.sv
module tb_uart_cfg_csr;

    localparam int DIV_W  = 16;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              i_wr_en;
    logic              i_rd_en;
    logic [2:0]        i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rvalid;
    logic              i_uart_busy;
    logic              o_parity_enable;
    logic              o_parity_type;
    logic              o_stop2;
    logic [1:0]        o_data_bits;
    logic [DIV_W-1:0]  o_baud_div;
    logic              o_cfg_update;
    logic              o_pending;

    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    uart_cfg_csr #(
        .CLK_FREQ(50_000_000), .DEF_BAUD(115200), .DIV_W(DIV_W), .DATA_W(DATA_W),
        .DEF_PARITY_EN(1), .DEF_PARITY_TYPE(0)
    ) dut (
        .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .i_uart_busy(i_uart_busy), .o_parity_enable(o_parity_enable),
        .o_parity_type(o_parity_type), .o_stop2(o_stop2), .o_data_bits(o_data_bits),
        .o_baud_div(o_baud_div), .o_cfg_update(o_cfg_update), .o_pending(o_pending)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic check_active(input string tag, input logic pen, input logic ptype,
                                input logic stop2, input logic [1:0] bits,
                                input logic [DIV_W-1:0] div);
        check({tag, "_pen"},   32'(o_parity_enable), 32'(pen));
        check({tag, "_ptype"}, 32'(o_parity_type),   32'(ptype));
        check({tag, "_stop2"}, 32'(o_stop2),         32'(stop2));
        check({tag, "_bits"},  32'(o_data_bits),     32'(bits));
        check({tag, "_div"},   32'(o_baud_div),      32'(div));
    endtask

    // Read scoreboard: each returned word is matched against the oldest
    // expectation pushed when its read was issued.
    always @(negedge clk) begin
        if (!rst && o_rvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rdata_unexpected: observed rvalid with data 0x%0h, required no read", o_rdata);
                $error("unexpected read return");
            end else begin
                check("rdata", o_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [DATA_W-1:0] data);
        i_wr_en = 1'b1;
        i_addr  = addr;
        i_wdata = data;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [DATA_W-1:0] exp);
        exp_q.push_back(exp);
        i_rd_en = 1'b1;
        i_addr  = addr;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [2:0] addr, input logic [DATA_W-1:0] data,
                         input logic [DATA_W-1:0] exp);
        exp_q.push_back(exp);
        i_wr_en = 1'b1;
        i_rd_en = 1'b1;
        i_addr  = addr;
        i_wdata = data;
        tick();
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bad_pending;
        int bad_update;
        int bad_div;

        rst = 1'b1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_addr = '0;
        i_wdata = '0;
        i_uart_busy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        check_active("reset", 1'b1, 1'b0, 1'b0, 2'd3, 16'd434);
        check("reset_update",  32'(o_cfg_update), 32'd0);
        check("reset_pending", 32'(o_pending),    32'd0);
        check("reset_rvalid",  32'(o_rvalid),     32'd0);
        check("reset_rdata",   o_rdata,           32'd0);
        rd(3'd3, 32'h0);
        rd(3'd0, 32'h19);
        rd(3'd1, 32'd434);

        // Basic apply with the UART idle
        wr(3'd1, 32'd868);
        wr(3'd0, 32'h1B);
        wr(3'd2, 32'h1);
        check("apply_pending", 32'(o_pending), 32'd1);
        check("apply_no_early_update", 32'(o_cfg_update), 32'd0);
        check("apply_old_div", 32'(o_baud_div), 32'd434);
        tick();
        check_active("apply", 1'b1, 1'b1, 1'b0, 2'd3, 16'd868);
        check("apply_update", 32'(o_cfg_update), 32'd1);
        check("apply_pending_clr", 32'(o_pending), 32'd0);
        tick();
        check("apply_update_end", 32'(o_cfg_update), 32'd0);
        rd(3'd4, 32'h1B);
        rd(3'd5, 32'd868);
        tick();
        check("rdata_hold_valid", 32'(o_rvalid), 32'd0);
        check("rdata_hold_value", o_rdata, 32'd868);

        // Apply held off by busy; a repeated apply has no extra effect
        wr(3'd0, 32'h05);
        i_uart_busy = 1'b1;
        wr(3'd2, 32'h1);
        check("busy_pending", 32'(o_pending), 32'd1);
        wr(3'd2, 32'h1);
        rd(3'd3, 32'h5);
        bad_pending = 0;
        bad_update = 0;
        bad_div = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_pending !== 1'b1) bad_pending++;
            if (o_cfg_update !== 1'b0) bad_update++;
            if (o_baud_div !== 16'd868 || o_stop2 !== 1'b0) bad_div++;
        end
        check("busy_hold_pending_cycles", 32'(bad_pending), 32'd0);
        check("busy_hold_update_cycles",  32'(bad_update),  32'd0);
        check("busy_hold_output_cycles",  32'(bad_div),     32'd0);
        i_uart_busy = 1'b0;
        tick();
        check_active("busy_commit", 1'b1, 1'b0, 1'b1, 2'd0, 16'd868);
        check("busy_commit_update", 32'(o_cfg_update), 32'd1);
        check("busy_commit_pending", 32'(o_pending), 32'd0);
        tick();
        check("busy_commit_single_pulse", 32'(o_cfg_update), 32'd0);
        check("busy_no_second_commit", 32'(o_pending), 32'd0);

        // Rejected divisors and error clearing
        wr(3'd1, 32'd1);
        rd(3'd3, 32'h2);
        rd(3'd1, 32'd868);
        wr(3'd2, 32'h2);
        rd(3'd3, 32'h0);
        wr(3'd1, 32'd0);
        rd(3'd3, 32'h2);
        wr(3'd2, 32'h3);
        check("cmd3_pending", 32'(o_pending), 32'd1);
        rd(3'd3, 32'h1);
        check("cmd3_update", 32'(o_cfg_update), 32'd1);
        check("cmd3_div_kept", 32'(o_baud_div), 32'd868);
        i_uart_busy = 1'b1;
        rd(3'd3, 32'h4);
        i_uart_busy = 1'b0;

        // Shadow write during the commit cycle
        wr(3'd1, 32'd200);
        wr(3'd2, 32'h1);
        wr(3'd1, 32'd100);
        check("commit_old_shadow_div", 32'(o_baud_div), 32'd200);
        check("commit_old_shadow_update", 32'(o_cfg_update), 32'd1);
        rd(3'd1, 32'd100);
        wr(3'd2, 32'h1);
        tick();
        check("second_apply_div", 32'(o_baud_div), 32'd100);

        // Apply written during the commit cycle -> second commit
        tick();
        wr(3'd0, 32'h1A);
        wr(3'd2, 32'h1);
        wr(3'd2, 32'h1);
        check("recommit_first_pen", 32'(o_parity_enable), 32'd0);
        check("recommit_first_update", 32'(o_cfg_update), 32'd1);
        check("recommit_pending", 32'(o_pending), 32'd1);
        tick();
        check("recommit_second_update", 32'(o_cfg_update), 32'd1);
        check("recommit_pending_clr", 32'(o_pending), 32'd0);
        tick();
        check("recommit_update_end", 32'(o_cfg_update), 32'd0);

        // Read and write in the same cycle
        wr_rd(3'd0, 32'h07, 32'h1A);
        rd(3'd0, 32'h07);

        // Unmapped and write-only addresses
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, 32'h0);
        rd(3'd2, 32'h0);
        check_active("unmapped_write", 1'b0, 1'b1, 1'b0, 2'd3, 16'd100);

        // Reset while an apply is pending
        i_uart_busy = 1'b1;
        wr(3'd2, 32'h1);
        check("pre_reset_pending", 32'(o_pending), 32'd1);
        rst = 1'b1;
        i_uart_busy = 1'b0;
        tick();
        check("rst_pending", 32'(o_pending), 32'd0);
        check("rst_update", 32'(o_cfg_update), 32'd0);
        check_active("rst", 1'b1, 1'b0, 1'b0, 2'd3, 16'd434);
        tick();
        check("rst_update_hold", 32'(o_cfg_update), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_update", 32'(o_cfg_update), 32'd0);
        check("post_rst_pending", 32'(o_pending), 32'd0);
        rd(3'd0, 32'h19);
        rd(3'd1, 32'd434);
        rd(3'd3, 32'h0);

        tick();
        tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cfg_csr.md
Name: uart_cfg_csr

Overview:
Runtime-programmable UART configuration block replacing fixed tie-off constants. Software writes parity, frame format and baud divisor into shadow registers over a simple single-cycle register port. An explicit apply command commits the shadow set to the active outputs, and the commit happens only while the UART reports idle. The block sits between the core's MMIO decode and the UART TX/RX engines.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
DEF_BAUD, 115200, baud rate loaded at reset
DIV_W, 16, width of the clocks-per-bit divisor
DATA_W, 32, register port data width (must be >= DIV_W and >= 5)
DEF_PARITY_EN, 1, parity enable at reset
DEF_PARITY_TYPE, 0, parity type at reset (0 even, 1 odd)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_wr_en  in  1  register write strobe, single cycle
i_rd_en  in  1  register read strobe, single cycle
i_addr  in  3  word address
i_wdata  in  DATA_W  write data
o_rdata  out  DATA_W  read data
o_rvalid  out  1  read data valid
i_uart_busy  in  1  TX or RX frame in progress
o_parity_enable  out  1  active parity enable
o_parity_type  out  1  active parity type (0 even, 1 odd)
o_stop2  out  1  active stop bits (0 one, 1 two)
o_data_bits  out  2  active data bits code (0=5, 1=6, 2=7, 3=8)
o_baud_div  out  DIV_W  active clocks per bit
o_cfg_update  out  1  one-cycle pulse when the active set changes
o_pending  out  1  an apply request is waiting

Behaviour:
- One clock domain. Reset is synchronous, active-high, and is named as stated above.
- Reset values:
  - Active and shadow registers: parity_en=DEF_PARITY_EN, parity_type=DEF_PARITY_TYPE, stop2=0, data_bits=3.
  - baud_div = CLK_FREQ/DEF_BAUD, integer truncation (434 with the defaults).
  - pending=0, err=0, o_rvalid=0, o_rdata=0, o_cfg_update=0.
- Register map:
  - 0 CTRL (R/W shadow): bit0 parity_en, bit1 parity_type, bit2 stop2, bits4:3 data_bits.
  - 1 BAUD (R/W shadow): bits DIV_W-1:0 divisor.
  - 2 CMD (W): bit0=1 requests apply, bit1=1 clears err. Reads return 0.
  - 3 STATUS (RO): bit0 pending, bit1 err, bit2 i_uart_busy.
  - 4 ACTIVE (RO): same layout as CTRL, reflecting the active outputs.
  - 5 ACTIVE_BAUD (RO): active divisor.
  - 6-7: reads return 0, writes ignored.
- Reads and writes:
  - Unused read bits return 0.
  - A read issued at cycle N presents o_rdata with o_rvalid=1 in cycle N+1. Otherwise o_rvalid=0 and o_rdata holds its last value.
  - Write and read in the same cycle are both served. A read of the written address returns the pre-write value.
- BAUD write with i_wdata[DIV_W-1:0] < 2: shadow divisor is unchanged and err sets (sticky). err clears only through CMD bit1 or reset.
- Apply request: a CMD write with bit0=1 sets pending on the next edge.
- Commit, evaluated every cycle with pending=1:
  - If i_uart_busy=0, then on that edge active <= shadow, pending <= 0, and o_cfg_update=1 for exactly the following cycle.
  - If i_uart_busy=1, pending holds and the outputs are unchanged. There is no timeout.
- Simultaneous events:
  - Shadow write in the commit cycle: the commit uses the old shadow value and the new value stays in shadow.
  - CMD apply write in the commit cycle: pending stays 1 and a second commit follows.
  - CMD apply while already pending: no additional effect.
  - CMD with bit0 and bit1 both set: both actions take place.
- Reset asserted mid-pending or during an o_cfg_update pulse: everything returns to reset values next edge and no pulse is generated.
- Active outputs are registered and change only at commit or reset. There is no combinational path from i_wdata to the active outputs.

Test Plan:
1. Reset release -> o_baud_div=434, o_parity_enable=1, o_parity_type=0, o_data_bits=3, o_stop2=0, STATUS read=0x0.
2. Write BAUD=868, CTRL=0x1B, CMD=1 with busy=0 -> pending for 1 cycle, then o_baud_div=868, o_data_bits=3, o_stop2=0, o_parity_type=1, o_parity_enable=1, one-cycle o_cfg_update.
3. CMD=1 while busy=1 for 20 cycles -> o_pending=1, outputs unchanged, no update. Busy falls -> commit on the next edge with a single pulse.
4. Write BAUD=1 -> STATUS=0x2 and BAUD readback unchanged. CMD=2 -> STATUS=0x0.
5. Write BAUD=100 in the same cycle as a commit of BAUD=200 -> active divisor=200, shadow readback=100. A second CMD=1 -> active=100.
6. Read at address 7 and at address 2 -> o_rvalid=1 one cycle later with o_rdata=0. Assert rst while pending -> pending=0, defaults restored, no o_cfg_update.
